i2s_sample_sink: RTL and testbench
==================================

Name: i2s_sample_sink

Overview:
- Codec-side consumer of the note player's sample stream.
- Paces sample production by pulsing generate_next_sample once per audio frame.
- Captures the returned signed 16-bit sample on sample_ready.
- Serialises the sample MSB-first, I2S format, to the codec: same sample on left and right slots (mono).
- Sits between the note player / mixer and the codec pins.

Parameters:
BCLK_DIV, 4, clk cycles per bclk half-period (legal range >= 2)
SLOT_BITS, 32, bclk periods per channel slot (legal range >= 18); a frame is 2*SLOT_BITS bclk periods

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  high = run the serial interface and request samples
sample_in  input  16  signed sample from the producer
sample_ready  input  1  sample_in valid this cycle
generate_next_sample  output  1  one-cycle request pulse to the producer
bclk  output  1  serial bit clock
lrclk  output  1  0 = left slot, 1 = right slot
sdata  output  1  serial data; changes only on bclk falling edges
underrun  output  1  one-cycle pulse: the previous request was never answered

Behaviour:
Reset (reset low, asynchronous):
- All outputs 0.
- Divider, bit counter, held sample and pending sample all 0.
- pending_valid = 0, req_outstanding = 0.
- Reset mid-frame aborts immediately; there is no partial-frame completion.

Divider and bclk:
- div counts 0..BCLK_DIV-1 while enable is high. A tick occurs when div == BCLK_DIV-1.
- bclk toggles on each tick.
- A tick that takes bclk 1->0 is a falling tick.

Bit counter and frame start:
- bit_cnt (range 0..2*SLOT_BITS-1) advances on each falling tick and wraps to 0.
- lrclk = 0 when bit_cnt < SLOT_BITS, else 1. It is registered and updated on the falling tick.
- A frame-start event is either:
  - a falling tick where bit_cnt wraps to 0, or
  - the first clk cycle with enable high after enable was low or after reset.

sdata (registered, updated on the falling tick together with lrclk):
- Let s = bit_cnt mod SLOT_BITS.
- s == 0: sdata = 0 (I2S one-bit delay).
- 1 <= s <= 16: sdata = held[16-s].
- s > 16: sdata = 0.

Sample handshake:
- At each frame-start event:
  - If pending_valid: held <= pending, pending_valid <= 0.
  - Else if req_outstanding: pulse underrun, keep held (the previous sample repeats).
- In the clk cycle after the frame-start event: generate_next_sample = 1 for exactly one cycle, and req_outstanding <= 1.
- sample_ready with req_outstanding = 1: pending <= sample_in, pending_valid <= 1, req_outstanding <= 0.
- sample_ready with req_outstanding = 0: ignored. Extra or duplicate ready pulses are dropped.
- sample_ready in the same cycle as a frame-start event:
  - The frame-start transfer uses the old pending.
  - The capture then proceeds normally.
- held changes only at frame-start events, so a slot never mixes two samples.

Disable (enable low):
- Synchronous to clk: div, bit_cnt and bclk are cleared next cycle; lrclk = 0, sdata = 0.
- No request pulses are issued.
- req_outstanding, pending_valid and underrun are cleared.
- held is kept.
- Re-enable starts a fresh frame at bit_cnt = 0 with a frame-start event.

Widths:
- held and pending are 16 bits.
- bit_cnt is clog2(2*SLOT_BITS) bits; div is clog2(BCLK_DIV) bits.

Test Plan:
1. Reset low, then release with enable=0 -> all outputs 0; bclk static.
2. BCLK_DIV=2, SLOT_BITS=32, enable=1 -> bclk period 4 clk; frame = 256 clk.
   - generate_next_sample pulses 1 clk after each frame start, 256 clk apart.
   - lrclk low for 128 clk, then high for 128 clk.
3. Respond to a request 3 clk later with 16'h8001 -> next frame, each slot shifts:
   - 0 at s=0, then 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1, then 15 zeros.
   - Identical data in the left and right slots.
4. Never assert sample_ready after a request -> underrun pulses at the next frame start; the previous held sample (e.g. 16'h8001) repeats bit-exactly.
5. Two sample_ready pulses (16'h1234, then 16'h5678) for one request -> 16'h1234 is transmitted; the second pulse is ignored.
6. Drop enable mid-left-slot, re-enable 10 clk later:
   - bclk, lrclk and sdata go to 0 the cycle after the drop.
   - On re-enable: a new frame starts at bit_cnt 0, a request pulse follows 1 clk later, and no underrun pulse occurs.

Source files
------------

// File: rtl/i2s_sample_sink_if.sv
// Sample handshake between the note player / mixer (master) and the I2S sink (slave).
// The producer answers each generate_next_sample pulse with one sample_ready cycle.
interface i2s_sample_sink_if;
  logic signed [15:0] sample_in;
  logic               sample_ready;
  logic               generate_next_sample;

  // Producer side: supplies samples on request.
  modport master (
    output sample_in,
    output sample_ready,
    input  generate_next_sample
  );

  // Sink side: requests samples and captures them.
  modport slave (
    input  sample_in,
    input  sample_ready,
    output generate_next_sample
  );
endinterface

// File: rtl/i2s_sample_sink.sv
// Codec-side consumer of the sample stream. Generates bclk/lrclk, requests one
// sample per frame and shifts it out MSB-first in I2S format on both slots (mono).
module i2s_sample_sink #(
  parameter int unsigned BCLK_DIV  = 4,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  i2s_sample_sink_if.slave      smp,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun
);

  localparam int unsigned FrameBits = 2 * SLOT_BITS;
  localparam int unsigned CntW      = $clog2(FrameBits);
  localparam int unsigned DivW      = $clog2(BCLK_DIV);

  localparam logic [DivW-1:0] DivLast    = DivW'(BCLK_DIV - 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(FrameBits - 1);
  localparam logic [CntW-1:0] SlotLen    = CntW'(SLOT_BITS);
  localparam logic [CntW-1:0] SampleBits = CntW'(16);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  // Serial interface state
  logic [DivW-1:0] div_q, div_d;
  logic            bclk_q, bclk_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            lrclk_q, lrclk_d;
  logic            sdata_q, sdata_d;
  logic            en_q, en_d;

  // Sample handshake state
  logic [15:0]     held_q, held_d;
  logic [15:0]     pending_q, pending_d;
  logic            pending_valid_q, pending_valid_d;
  logic            req_q, req_d;
  logic            gen_q, gen_d;
  logic            underrun_q, underrun_d;

  // Decoded timing events
  logic            tick;
  logic            fall_tick;
  logic            frame_start;
  logic [CntW-1:0] bit_cnt_nxt;
  logic [CntW-1:0] slot_pos;
  logic [3:0]      bit_idx;
  logic            data_bit;

  assign tick        = enable && (div_q == DivLast);
  assign fall_tick   = tick && bclk_q;
  // A frame starts on the wrap of the bit counter or on the first enabled cycle.
  assign frame_start = enable && (!en_q || (fall_tick && (bit_cnt_q == CntLast)));

  assign bit_cnt_nxt = (bit_cnt_q == CntLast) ? '0 : bit_cnt_q + CntOne;

  // Position inside the slot that the next falling tick moves into.
  always_comb begin
    slot_pos = bit_cnt_nxt;
    if (bit_cnt_nxt >= SlotLen) begin
      slot_pos = bit_cnt_nxt - SlotLen;
    end
  end

  // Slot position 0 is the I2S one-bit delay; positions 1..16 carry the sample MSB-first.
  always_comb begin
    bit_idx  = 4'(SampleBits - slot_pos);
    data_bit = 1'b0;
    if ((slot_pos >= CntOne) && (slot_pos <= SampleBits)) begin
      data_bit = held_q[bit_idx];
    end
  end

  // Next-state logic for the divider, bit clock, framing and sample handshake.
  always_comb begin
    div_d           = div_q;
    bclk_d          = bclk_q;
    bit_cnt_d       = bit_cnt_q;
    lrclk_d         = lrclk_q;
    sdata_d         = sdata_q;
    en_d            = enable;
    held_d          = held_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    req_d           = req_q;
    gen_d           = 1'b0;
    underrun_d      = 1'b0;

    if (!enable) begin
      // Idle: pins quiet, handshake forgotten, held sample retained for re-enable.
      div_d           = '0;
      bclk_d          = 1'b0;
      bit_cnt_d       = '0;
      lrclk_d         = 1'b0;
      sdata_d         = 1'b0;
      pending_valid_d = 1'b0;
      req_d           = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        bclk_d = ~bclk_q;
      end
      if (fall_tick) begin
        bit_cnt_d = bit_cnt_nxt;
        lrclk_d   = (bit_cnt_nxt >= SlotLen);
        sdata_d   = data_bit;
      end

      // Held only changes here, so a slot never mixes two samples.
      if (frame_start) begin
        if (pending_valid_q) begin
          held_d          = pending_q;
          pending_valid_d = 1'b0;
        end else if (req_q) begin
          underrun_d = 1'b0 | 1'b1;
        end
      end

      // Capture after the frame-start transfer so a coincident ready is not lost.
      if (smp.sample_ready && req_q) begin
        pending_d       = smp.sample_in;
        pending_valid_d = 1'b1;
        req_d           = 1'b0;
      end

      if (frame_start) begin
        gen_d = 1'b1;
        req_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q           <= '0;
      bclk_q          <= 1'b0;
      bit_cnt_q       <= '0;
      lrclk_q         <= 1'b0;
      sdata_q         <= 1'b0;
      en_q            <= 1'b0;
      held_q          <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      req_q           <= 1'b0;
      gen_q           <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      div_q           <= div_d;
      bclk_q          <= bclk_d;
      bit_cnt_q       <= bit_cnt_d;
      lrclk_q         <= lrclk_d;
      sdata_q         <= sdata_d;
      en_q            <= en_d;
      held_q          <= held_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      req_q           <= req_d;
      gen_q           <= gen_d;
      underrun_q      <= underrun_d;
    end
  end

  assign bclk                     = bclk_q;
  assign lrclk                    = lrclk_q;
  assign sdata                    = sdata_q;
  assign underrun                 = underrun_q;
  assign smp.generate_next_sample = gen_q;

endmodule

// File: tb/tb_i2s_sample_sink.sv
// Self-checking bench for i2s_sample_sink: per-scenario tasks, randomized samples and
// response delays, checked against a transaction-level model of the sample handshake.
module tb_i2s_sample_sink;

  localparam int unsigned BclkDiv  = 2;
  localparam int unsigned SlotBits = 32;
  localparam logic [63:0] ExpLr    = {32'hFFFF_FFFF, 32'h0000_0000};

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic bclk, lrclk, sdata, underrun;

  i2s_sample_sink_if smp ();

  i2s_sample_sink #(
    .BCLK_DIV  (BclkDiv),
    .SLOT_BITS (SlotBits)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .enable   (enable),
    .smp      (smp),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model of the handshake
  logic [15:0] m_held, m_pending;
  bit          m_pv, m_req;

  task automatic model_reset();
    m_held = '0; m_pending = '0; m_pv = 0; m_req = 0;
  endtask

  task automatic model_frame_start(output bit exp_urun);
    exp_urun = 0;
    if (m_pv) begin
      m_held = m_pending;
      m_pv   = 0;
    end else if (m_req) begin
      exp_urun = 1;
    end
    m_req = 1;
  endtask

  task automatic model_ready(input logic [15:0] v);
    if (m_req) begin
      m_pending = v;
      m_pv      = 1;
      m_req     = 0;
    end
  endtask

  task automatic model_disable();
    m_req = 0; m_pv = 0;
  endtask

  // Expected 64 bits of a frame, bit k = k-th bclk period after frame start.
  function automatic logic [63:0] exp_data(input logic [15:0] v);
    logic [63:0] d;
    int s;
    d = '0;
    for (int k = 0; k < 64; k++) begin
      s = k % 32;
      if (s >= 1 && s <= 16) d[k] = v[16-s];
    end
    return d;
  endfunction

  // Monitor: collects sdata/lrclk on bclk rising edges, framed by request pulses.
  logic [63:0] cur_d, cur_l, last_d, last_l;
  int          cur_n, last_n;
  logic        prev_bclk;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_n <= 0;
      cur_d <= '0;
      cur_l <= '0;
    end else if (smp.generate_next_sample === 1'b1) begin
      last_d <= cur_d;
      last_l <= cur_l;
      last_n <= cur_n;
      cur_n  <= 0;
      cur_d  <= '0;
      cur_l  <= '0;
    end else if (bclk === 1'b1 && prev_bclk === 1'b0 && cur_n < 64) begin
      cur_d[cur_n[5:0]] <= sdata;
      cur_l[cur_n[5:0]] <= lrclk;
      cur_n             <= cur_n + 1;
    end
    prev_bclk <= bclk;
  end

  // Waits for a request pulse (bounded); returns the underrun seen in that cycle.
  task automatic wait_gen(output bit ok, output int waited, output logic urun);
    ok = 0; waited = 0; urun = 1'bx;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      waited++;
      if (smp.generate_next_sample === 1'b1) begin
        ok   = 1;
        urun = underrun;
        break;
      end
    end
    #1;
  endtask

  task automatic respond(input int delay, input logic [15:0] v);
    repeat (delay - 1) @(posedge clk);
    @(posedge clk); #1;
    smp.sample_ready = 1'b1;
    smp.sample_in    = v;
    @(posedge clk); #1;
    smp.sample_ready = 1'b0;
    smp.sample_in    = 16'($urandom);
    model_ready(v);
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0; enable = 1'b0;
    smp.sample_ready = 1'b0; smp.sample_in = '0;
    model_reset();
    #12;
    n_checks++;
    if ({smp.generate_next_sample, bclk, lrclk, sdata, underrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {smp.generate_next_sample, bclk, lrclk, sdata, underrun});
    end
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if ({smp.generate_next_sample, bclk, lrclk, sdata, underrun} !== 5'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL idle_outputs: got activity with enable low, expected all 0");
    end
  endtask

  task automatic test_pacing();
    bit ok; int waited; logic urun; bit exp_u;
    int lo, hi, gens, rises; logic gen_end, urun_end, pb;
    logic [15:0] exp_v;
    @(posedge clk); #1 enable = 1'b1;
    wait_gen(ok, waited, urun);
    n_checks++;
    if (!ok || waited != 2) begin
      n_fail++;
      $display("FAIL first_request_latency: got ok=%0d waited=%0d expected waited=2", ok, waited);
    end
    model_frame_start(exp_u);
    n_checks++;
    if (urun !== exp_u) begin
      n_fail++;
      $display("FAIL first_underrun: got %b expected %b", urun, exp_u);
    end
    @(negedge clk);
    n_checks++;
    if (smp.generate_next_sample !== 1'b0) begin
      n_fail++;
      $display("FAIL request_width: got %b expected 0", smp.generate_next_sample);
    end
    wait_gen(ok, waited, urun);
    model_frame_start(exp_u);
    n_checks++;
    if (!ok || urun !== exp_u) begin
      n_fail++;
      $display("FAIL second_frame_underrun: got ok=%0d urun=%b expected %b", ok, urun, exp_u);
    end
    lo = 0; hi = 0; gens = 0; rises = 0; gen_end = 0; urun_end = 0; pb = bclk;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (lrclk) hi++; else lo++;
      if (bclk && !pb) rises++;
      pb = bclk;
      if (smp.generate_next_sample) begin
        gens++;
        if (i == 256) begin gen_end = 1; urun_end = underrun; end
      end
    end
    #1;
    n_checks++;
    if (gens != 1 || !gen_end) begin
      n_fail++;
      $display("FAIL frame_period: got %0d pulses, end=%b expected one pulse 256 clk later",
               gens, gen_end);
    end
    n_checks++;
    if (lo != 128 || hi != 128) begin
      n_fail++;
      $display("FAIL lrclk_duty: got low=%0d high=%0d expected 128/128", lo, hi);
    end
    n_checks++;
    if (rises != 64) begin
      n_fail++;
      $display("FAIL bclk_period: got %0d rising edges expected 64", rises);
    end
    exp_v = m_held;
    model_frame_start(exp_u);
    n_checks++;
    if (urun_end !== exp_u) begin
      n_fail++;
      $display("FAIL third_frame_underrun: got %b expected %b", urun_end, exp_u);
    end
    n_checks++;
    if (last_n != 64 || last_d !== exp_data(exp_v) || last_l !== ExpLr) begin
      n_fail++;
      $display("FAIL pacing_frame: got n=%0d d=%h l=%h expected d=%h l=%h",
               last_n, last_d, last_l, exp_data(exp_v), ExpLr);
    end
  endtask

  // Frame i0: answer with 16'h8001; later frames unanswered, so it must repeat.
  task automatic test_serial();
    bit ok; int waited; logic urun; bit exp_u; logic [15:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      wait_gen(ok, waited, urun);
      exp_v = m_held;
      model_frame_start(exp_u);
      n_checks++;
      if (!ok || urun !== exp_u) begin
        n_fail++;
        $display("FAIL serial_underrun[%0d]: got ok=%0d urun=%b expected %b", i, ok, urun, exp_u);
      end
      if (i > 0) begin
        n_checks++;
        if (last_n != 64 || last_d !== exp_data(exp_v) || last_l !== ExpLr) begin
          n_fail++;
          $display("FAIL serial_frame[%0d]: got n=%0d d=%h l=%h expected d=%h l=%h",
                   i, last_n, last_d, last_l, exp_data(exp_v), ExpLr);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (last_d[31:0] !== last_d[63:32] || last_d[31:0] !== 32'h0001_0002) begin
          n_fail++;
          $display("FAIL serial_mono_8001: got left=%h right=%h expected 00010002 both",
                   last_d[31:0], last_d[63:32]);
        end
      end
      if (i == 0) respond(3, 16'h8001);
    end
  endtask

  task automatic test_duplicate();
    bit ok; int waited; logic urun; bit exp_u; logic [15:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      wait_gen(ok, waited, urun);
      exp_v = m_held;
      model_frame_start(exp_u);
      n_checks++;
      if (!ok || urun !== exp_u) begin
        n_fail++;
        $display("FAIL dup_underrun[%0d]: got ok=%0d urun=%b expected %b", i, ok, urun, exp_u);
      end
      n_checks++;
      if (last_n != 64 || last_d !== exp_data(exp_v) || last_l !== ExpLr) begin
        n_fail++;
        $display("FAIL dup_frame[%0d]: got n=%0d d=%h expected d=%h",
                 i, last_n, last_d, exp_data(exp_v));
      end
      if (i == 0) begin
        respond(5, 16'h1234);
        respond(5, 16'h5678);
      end
    end
  endtask

  task automatic test_random();
    bit ok; int waited; logic urun; bit exp_u; logic [15:0] exp_v; int r;
    for (int i = 0; i < 8; i++) begin
      wait_gen(ok, waited, urun);
      exp_v = m_held;
      model_frame_start(exp_u);
      n_checks++;
      if (!ok || urun !== exp_u) begin
        n_fail++;
        $display("FAIL rand_underrun[%0d]: got ok=%0d urun=%b expected %b", i, ok, urun, exp_u);
      end
      n_checks++;
      if (last_n != 64 || last_d !== exp_data(exp_v) || last_l !== ExpLr) begin
        n_fail++;
        $display("FAIL rand_frame[%0d]: got n=%0d d=%h expected d=%h (sample %h)",
                 i, last_n, last_d, exp_data(exp_v), exp_v);
      end
      r = int'($urandom_range(0, 3));
      if (r != 0) respond(int'($urandom_range(1, 120)), 16'($urandom));
      if (r == 3) respond(int'($urandom_range(1, 60)), 16'($urandom));
    end
  endtask

  task automatic test_disable();
    bit ok; int waited; logic urun; bit exp_u; logic [15:0] v, exp_v;
    bit found; int busy;
    v = 16'($urandom) | 16'h8000;
    wait_gen(ok, waited, urun);
    model_frame_start(exp_u);
    respond(2, v);
    wait_gen(ok, waited, urun);
    model_frame_start(exp_u);
    n_checks++;
    if (!ok || urun !== exp_u) begin
      n_fail++;
      $display("FAIL dis_pre_underrun: got ok=%0d urun=%b expected %b", ok, urun, exp_u);
    end
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bclk && sdata && !lrclk) begin found = 1; break; end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL dis_find_data: got no high sdata in left slot, expected bit 15 = 1");
    end
    @(posedge clk); #1 enable = 1'b0;
    model_disable();
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bclk, lrclk, sdata} !== 3'b000) begin
      n_fail++;
      $display("FAIL dis_pins: got bclk/lrclk/sdata=%b expected 000", {bclk, lrclk, sdata});
    end
    busy = 0;
    repeat (9) begin
      @(negedge clk);
      if (smp.generate_next_sample || underrun || bclk) busy++;
    end
    n_checks++;
    if (busy != 0) begin
      n_fail++;
      $display("FAIL dis_quiet: got %0d active cycles expected 0", busy);
    end
    @(posedge clk); #1 enable = 1'b1;
    wait_gen(ok, waited, urun);
    model_frame_start(exp_u);
    n_checks++;
    if (!ok || waited != 2) begin
      n_fail++;
      $display("FAIL reenable_latency: got ok=%0d waited=%0d expected waited=2", ok, waited);
    end
    n_checks++;
    if (urun !== exp_u) begin
      n_fail++;
      $display("FAIL reenable_underrun: got %b expected %b", urun, exp_u);
    end
    wait_gen(ok, waited, urun);
    exp_v = m_held;
    model_frame_start(exp_u);
    n_checks++;
    if (!ok || last_n != 64 || last_d !== exp_data(exp_v) || last_l !== ExpLr) begin
      n_fail++;
      $display("FAIL reenable_frame: got n=%0d d=%h expected d=%h (held %h)",
               last_n, last_d, exp_data(exp_v), exp_v);
    end
  endtask

  task automatic test_async_reset();
    bit ok; int waited; logic urun; bit exp_u; logic [15:0] exp_v; bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bclk) begin found = 1; break; end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!found || {smp.generate_next_sample, bclk, lrclk, sdata, underrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got found=%0d outputs=%b expected 00000",
               found, {smp.generate_next_sample, bclk, lrclk, sdata, underrun});
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gen(ok, waited, urun);
      exp_v = m_held;
      model_frame_start(exp_u);
      n_checks++;
      if (!ok || urun !== exp_u) begin
        n_fail++;
        $display("FAIL post_reset_underrun[%0d]: got ok=%0d urun=%b expected %b",
                 i, ok, urun, exp_u);
      end
      if (i > 0) begin
        n_checks++;
        if (last_n != 64 || last_d !== exp_data(exp_v) || last_l !== ExpLr) begin
          n_fail++;
          $display("FAIL post_reset_frame[%0d]: got n=%0d d=%h expected d=%h",
                   i, last_n, last_d, exp_data(exp_v));
        end
      end
      if (i == 1) respond(int'($urandom_range(1, 100)), 16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_serial();
    test_duplicate();
    test_random();
    test_disable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
